fifo_sync_mode: RTL

Parametrised synchronous FIFO, the successor to the single-mode sync FIFO in the image-processing datapath. It adds a selectable read mode: standard registered read or first-word-fall-through (FWFT). It also adds programmable almost-full/almost-empty thresholds, a synchronous flush, and a read-valid strobe. It sits between line-buffer/pixel stages that need back-pressure margin before full/empty.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/fifo_mem.sv | 24 ++
 rtl/fifo_sync_mode.sv | 130 +++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and elaboration helpers for the mode-selectable synchronous FIFO.
package fifo_pkg;

    localparam int unsigned FIFO_MODE_STD  = 0;
    localparam int unsigned FIFO_MODE_FWFT = 1;

    // Occupancy counter must represent 0..SIZE inclusive.
    function automatic int unsigned count_w(input int unsigned size);
        return $clog2(size) + 1;
    endfunction

    function automatic bit fifo_params_ok(
        input int unsigned data_w,
        input int unsigned size,
        input int unsigned fwft,
        input int unsigned af_thresh,
        input int unsigned ae_thresh
    );
        return (data_w >= 1) && (size >= 2) && ((size & (size - 1)) == 0) &&
               (fwft <= 1) && (af_thresh >= 1) && (af_thresh <= size) &&
               (ae_thresh <= size - 1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: register array, synchronous write, asynchronous read, not reset.
module fifo_mem #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned SIZE   = 16
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [$clog2(SIZE)-1:0] waddr,
    input  logic [DATA_W-1:0]       wdata,
    input  logic [$clog2(SIZE)-1:0] raddr,
    output logic [DATA_W-1:0]       rdata
);

    logic [DATA_W-1:0] mem [SIZE];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_mode.sv
// Synchronous FIFO with standard or first-word-fall-through read, almost flags,
// synchronous flush and read-valid strobe.
module fifo_sync_mode
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = 10,
    parameter int unsigned SIZE      = 16,
    parameter int unsigned FWFT      = FIFO_MODE_STD,
    parameter int unsigned AF_THRESH = SIZE - 4,
    parameter int unsigned AE_THRESH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic [DATA_W-1:0]            data_wr,
    input  logic                         wr_en,
    output logic [DATA_W-1:0]            data_rd,
    input  logic                         rd_en,
    output logic                         rd_valid,
    output logic [count_w(SIZE)-1:0]     data_count,
    output logic                         full,
    output logic                         almost_full,
    output logic                         empty,
    output logic                         almost_empty,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int unsigned PTR_W = $clog2(SIZE);
    localparam int unsigned CNT_W = count_w(SIZE);

    if (!fifo_params_ok(DATA_W, SIZE, FWFT, AF_THRESH, AE_THRESH)) begin : g_bad_params
        $error("fifo_sync_mode: illegal parameter combination");
    end

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d, af_q, af_d, empty_q, empty_d, ae_q, ae_d;
    logic              ovf_q, ovf_d, udf_q, udf_d, rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] data_rd_q, data_rd_d, mem_rdata;
    logic              rd_accept, wr_accept, rd_do, wr_do;

    fifo_mem #(
        .DATA_W (DATA_W),
        .SIZE   (SIZE)
    ) u_mem (
        .clk   (clk),
        .we    (wr_do),
        .waddr (wr_ptr_q),
        .wdata (data_wr),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

    // Next-state: flush wins over any request in the same cycle.
    always_comb begin
        rd_accept  = rd_en && !empty_q;
        wr_accept  = wr_en && (!full_q || rd_accept);
        rd_do      = !flush && rd_accept;
        wr_do      = !flush && wr_accept;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_rd_d  = data_rd_q;
        rd_valid_d = 1'b0;
        ovf_d      = 1'b0;
        udf_d      = 1'b0;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_do) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (rd_do) begin
                rd_ptr_d  = rd_ptr_q + PTR_W'(1);
                data_rd_d = mem_rdata;
            end
            count_d    = count_q + CNT_W'(wr_do) - CNT_W'(rd_do);
            rd_valid_d = rd_do;
            ovf_d      = wr_en && !wr_accept;
            udf_d      = rd_en && !rd_accept;
        end
        full_d  = (count_d == CNT_W'(SIZE));
        af_d    = (count_d >= CNT_W'(AF_THRESH));
        empty_d = (count_d == '0);
        ae_d    = (count_d <= CNT_W'(AE_THRESH));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            af_q       <= 1'b0;
            empty_q    <= 1'b1;
            ae_q       <= 1'b1;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            data_rd_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            af_q       <= af_d;
            empty_q    <= empty_d;
            ae_q       <= ae_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            rd_valid_q <= rd_valid_d;
            data_rd_q  <= data_rd_d;
        end
    end

    // FWFT presents the head directly; gated to zero while empty so reset shows 0.
    assign data_rd      = (FWFT == FIFO_MODE_FWFT) ? (empty_q ? '0 : mem_rdata) : data_rd_q;
    assign rd_valid     = (FWFT == FIFO_MODE_FWFT) ? !empty_q : rd_valid_q;
    assign data_count   = count_q;
    assign full         = full_q;
    assign almost_full  = af_q;
    assign empty        = empty_q;
    assign almost_empty = ae_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule
